// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I datapath and its sequencer.
// master: the control FSM (drives strobes and mux selects).
// slave:  the datapath (drives Op/Funct3/Zero, memory drives MemReady).
// Optional macro ILLEGAL_TRAP_EN adds the IllegalInstr status output.
interface multicycle_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Op;
   logic [2:0]       Funct3;
   logic             Zero;
   logic             MemReady;
   logic             MemReq;
   logic             PCWrite;
   logic             AdrSrc;
   logic             IRWrite;
   logic             MemWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       ImmSrc;
   logic [CNT_W-1:0] InstrRetired;
   logic [3:0]       State;
`ifdef ILLEGAL_TRAP_EN
   logic             IllegalInstr;
`endif

`ifdef ILLEGAL_TRAP_EN
   modport master (
      input  Op, Funct3, Zero, MemReady,
      output MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      output InstrRetired, State, IllegalInstr
   );
   modport slave (
      output Op, Funct3, Zero, MemReady,
      input  MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      input  InstrRetired, State, IllegalInstr
   );
`else
   modport master (
      input  Op, Funct3, Zero, MemReady,
      output MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      output InstrRetired, State
   );
   modport slave (
      output Op, Funct3, Zero, MemReady,
      input  MemReq, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      input  InstrRetired, State
   );
`endif
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RV32I core (R, I-ALU, lw, sw, beq/bne).
// Mux selects and strobe enables are registered from the next state; strobes
// that depend on the memory handshake or the branch condition are gated
// combinationally with MemReady / Zero, and every strobe is forced low while
// rst_n is asserted. Also counts retired instructions (wraps at 2^CNT_W).
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP and
// raise IllegalInstr; without it they behave as a NOP.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC, wait for MemReady
// DECODE   | read registers, PC-relative branch target into ALUOut
// MEMADR   | rs1 + imm -> load/store address
// MEMREAD  | load data access, wait for MemReady
// MEMWB    | write loaded data to rd (retire)
// MEMWRITE | store data access, wait for MemReady (retire on ready)
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALU result to rd (retire)
// BRANCH   | compare rs1/rs2, take target if condition holds (retire)
// TRAP     | illegal opcode seen, hold until reset (ILLEGAL_TRAP_EN only)
module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_control_fsm_if.master bus
);

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
`ifdef ILLEGAL_TRAP_EN
      , TRAP   = 4'd10
`endif
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic             memreq_q;
   logic             fetch_q;
   logic             memwr_q;
   logic             regwrite_q;
   logic             branch_q;
   logic             adrsrc_q;
   logic [1:0]       ressrc_q;
   logic [1:0]       srca_q;
   logic [1:0]       srcb_q;
   logic [1:0]       aluop_q;
   logic             trap_q;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   logic             take_branch;
   logic [1:0]       immsrc;
   logic             unused_funct3;

   // Only bit 0 of funct3 matters to the sequencer (beq vs bne).
   assign unused_funct3 = ^bus.Funct3[2:1];

   // Next-state decode; Op/Funct3 come from the IR, which is stable after FETCH.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         FETCH:    if (bus.MemReady) state_nxt = DECODE;
         DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_R:         state_nxt = EXECR;
               OP_I:         state_nxt = EXECI;
               OP_B:         state_nxt = BRANCH;
`ifdef ILLEGAL_TRAP_EN
               default:      state_nxt = TRAP;
`else
               default:      state_nxt = FETCH;
`endif
            endcase
         end
         MEMADR:   state_nxt = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  if (bus.MemReady) state_nxt = MEMWB;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: if (bus.MemReady) state_nxt = FETCH;
         EXECR:    state_nxt = ALUWB;
         EXECI:    state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         BRANCH:   state_nxt = FETCH;
`ifdef ILLEGAL_TRAP_EN
         TRAP:     state_nxt = TRAP;
`endif
         default:  state_nxt = FETCH;
      endcase
   end

   // State register plus registered Moore outputs decoded from the next state,
   // so every output is valid from the first cycle of its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         memreq_q   <= 1'b1;
         fetch_q    <= 1'b1;
         memwr_q    <= 1'b0;
         regwrite_q <= 1'b0;
         branch_q   <= 1'b0;
         adrsrc_q   <= 1'b0;
         ressrc_q   <= 2'b10;
         srca_q     <= 2'b00;
         srcb_q     <= 2'b10;
         aluop_q    <= 2'b00;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         memreq_q   <= 1'b0;
         fetch_q    <= 1'b0;
         memwr_q    <= 1'b0;
         regwrite_q <= 1'b0;
         branch_q   <= 1'b0;
         adrsrc_q   <= 1'b0;
         ressrc_q   <= 2'b00;
         srca_q     <= 2'b00;
         srcb_q     <= 2'b00;
         aluop_q    <= 2'b00;
         trap_q     <= 1'b0;
         case (state_nxt)
            FETCH: begin
               memreq_q <= 1'b1;
               fetch_q  <= 1'b1;
               srcb_q   <= 2'b10;
               ressrc_q <= 2'b10;
            end
            DECODE: begin
               srca_q <= 2'b01;
               srcb_q <= 2'b01;
            end
            MEMADR: begin
               srca_q <= 2'b10;
               srcb_q <= 2'b01;
            end
            MEMREAD: begin
               memreq_q <= 1'b1;
               adrsrc_q <= 1'b1;
            end
            MEMWB: begin
               ressrc_q   <= 2'b01;
               regwrite_q <= 1'b1;
            end
            MEMWRITE: begin
               memreq_q <= 1'b1;
               adrsrc_q <= 1'b1;
               memwr_q  <= 1'b1;
            end
            EXECR: begin
               srca_q  <= 2'b10;
               srcb_q  <= 2'b00;
               aluop_q <= 2'b10;
            end
            EXECI: begin
               srca_q  <= 2'b10;
               srcb_q  <= 2'b01;
               aluop_q <= 2'b10;
            end
            ALUWB: begin
               regwrite_q <= 1'b1;
            end
            BRANCH: begin
               srca_q   <= 2'b10;
               aluop_q  <= 2'b01;
               branch_q <= 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
               trap_q <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // Exactly one retire cycle per instruction: the writeback states, the
   // branch state, or the completing cycle of a store.
   assign retire      = regwrite_q | branch_q | (memwr_q & bus.MemReady);
   assign take_branch = bus.Zero ^ bus.Funct3[0];

   // Retired-instruction counter, free-running modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (retire) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Immediate format is a pure function of the opcode.
   always_comb begin
      immsrc = 2'b00;
      case (bus.Op)
         OP_SW:   immsrc = 2'b01;
         OP_B:    immsrc = 2'b10;
         default: immsrc = 2'b00;
      endcase
   end

   assign bus.MemReq       = rst_n & memreq_q;
   assign bus.IRWrite      = rst_n & fetch_q & bus.MemReady;
   assign bus.PCWrite      = rst_n & ((fetch_q & bus.MemReady) | (branch_q & take_branch));
   assign bus.MemWrite     = rst_n & memwr_q & bus.MemReady;
   assign bus.RegWrite     = rst_n & regwrite_q;
   assign bus.AdrSrc       = adrsrc_q;
   assign bus.ResultSrc    = ressrc_q;
   assign bus.ALUSrcA      = srca_q;
   assign bus.ALUSrcB      = srcb_q;
   assign bus.ALUOp        = aluop_q;
   assign bus.ImmSrc       = immsrc;
   assign bus.InstrRetired = cnt_q;
   assign bus.State        = state_q;
`ifdef ILLEGAL_TRAP_EN
   assign bus.IllegalInstr = trap_q;
`else
   logic unused_trap;
   assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level reference model pushes
// one expected output record per cycle into a queue; a monitor pops and
// compares on every falling edge. Small CNT_W so the counter wraps.
module tb_multicycle_control_fsm;

   localparam int CNT_W = 8;

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
   localparam int P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;
   localparam int P_TRAP = 10;

   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_ILL = 6;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   typedef struct packed {
      logic [3:0]       st;
      logic             memreq;
      logic             pcwrite;
      logic             adrsrc;
      logic             irwrite;
      logic             memwrite;
      logic             regwrite;
      logic [1:0]       ressrc;
      logic [1:0]       srca;
      logic [1:0]       srcb;
      logic [1:0]       aluop;
      logic [1:0]       immsrc;
      logic             ill;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   obs_t exp_q[$];
   logic [CNT_W-1:0] mcnt = '0;
   logic       load_ir = 1'b0;
   logic [6:0] pend_op = '0;
   logic [2:0] pend_f3 = '0;

   multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

   multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic obs_t expect_out(input int ph, input logic rdy, input logic z,
                                       input logic [2:0] f3, input logic [6:0] op,
                                       input logic [CNT_W-1:0] cnt);
      obs_t e;
      e = '0;
      e.st = ph[3:0];
      e.cnt = cnt;
      e.immsrc = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : 2'b00;
      case (ph)
         P_FETCH: begin
            e.memreq = 1'b1; e.pcwrite = rdy; e.irwrite = rdy;
            e.srcb = 2'b10; e.ressrc = 2'b10;
         end
         P_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
         P_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
         P_MEMREAD:  begin e.memreq = 1'b1; e.adrsrc = 1'b1; end
         P_MEMWB:    begin e.ressrc = 2'b01; e.regwrite = 1'b1; end
         P_MEMWRITE: begin e.memreq = 1'b1; e.adrsrc = 1'b1; e.memwrite = rdy; end
         P_EXECR:    begin e.srca = 2'b10; e.srcb = 2'b00; e.aluop = 2'b10; end
         P_EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
         P_ALUWB:    begin e.regwrite = 1'b1; end
         P_BRANCH:   begin e.srca = 2'b10; e.aluop = 2'b01; e.pcwrite = z ^ f3[0]; end
         P_TRAP:     begin e.ill = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   // One clock cycle of a given phase: drive inputs after the edge, queue the
   // expected outputs, and advance the model's retire count.
   task automatic cyc(input int ph, input logic rdy, input int zf);
      logic z;
      @(posedge clk);
      #1;
      if (load_ir) begin
         bus.Op = pend_op;
         bus.Funct3 = pend_f3;
         load_ir = 1'b0;
      end
      z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      bus.Zero = z;
      bus.MemReady = rdy;
      exp_q.push_back(expect_out(ph, rdy, z, bus.Funct3, bus.Op, mcnt));
      if (ph == P_MEMWB || ph == P_ALUWB || ph == P_BRANCH || (ph == P_MEMWRITE && rdy))
         mcnt = mcnt + 1'b1;
   endtask

   task automatic rnd(input int ph);
      cyc(ph, 1'($urandom_range(0, 1)), -1);
   endtask

   task automatic mem(input int ph, input int waits);
      for (int i = 0; i < waits; i++) cyc(ph, 1'b0, -1);
      cyc(ph, 1'b1, -1);
   endtask

   function automatic logic [6:0] illegal_op();
      logic [6:0] op;
      do op = 7'($urandom_range(0, 127));
      while (op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_B);
      return op;
   endfunction

   task automatic run(input int k, input int wf, input int wm, input int zf);
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      case (k)
         K_R:   pend_op = OP_R;
         K_I:   pend_op = OP_I;
         K_LW:  pend_op = OP_LW;
         K_SW:  pend_op = OP_SW;
         K_BEQ: begin pend_op = OP_B; f3[0] = 1'b0; end
         K_BNE: begin pend_op = OP_B; f3[0] = 1'b1; end
         default: pend_op = (k == K_ILL) ? 7'b1111111 : illegal_op();
      endcase
      pend_f3 = f3;
      load_ir = 1'b1;
      mem(P_FETCH, wf);
      rnd(P_DECODE);
      case (k)
         K_R:   begin rnd(P_EXECR); rnd(P_ALUWB); end
         K_I:   begin rnd(P_EXECI); rnd(P_ALUWB); end
         K_LW:  begin rnd(P_MEMADR); mem(P_MEMREAD, wm); rnd(P_MEMWB); end
         K_SW:  begin rnd(P_MEMADR); mem(P_MEMWRITE, wm); end
         K_BEQ, K_BNE: cyc(P_BRANCH, 1'($urandom_range(0, 1)), zf);
         default: begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 6; i++) rnd(P_TRAP);
`endif
         end
      endcase
   endtask

   // Scoreboard monitor: compare one queued record per falling edge.
   initial begin
      obs_t a, e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.st = bus.State; a.memreq = bus.MemReq; a.pcwrite = bus.PCWrite;
            a.adrsrc = bus.AdrSrc; a.irwrite = bus.IRWrite; a.memwrite = bus.MemWrite;
            a.regwrite = bus.RegWrite; a.ressrc = bus.ResultSrc; a.srca = bus.ALUSrcA;
            a.srcb = bus.ALUSrcB; a.aluop = bus.ALUOp; a.immsrc = bus.ImmSrc;
`ifdef ILLEGAL_TRAP_EN
            a.ill = bus.IllegalInstr;
`else
            a.ill = 1'b0;
`endif
            a.cnt = bus.InstrRetired;
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL cycle_out t=%0t act=%h exp=%h", $time, a, e);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"},    64'(bus.State), 64'd0);
      chk({tag, "_memreq"},   64'(bus.MemReq), 64'd0);
      chk({tag, "_irwrite"},  64'(bus.IRWrite), 64'd0);
      chk({tag, "_pcwrite"},  64'(bus.PCWrite), 64'd0);
      chk({tag, "_memwrite"}, 64'(bus.MemWrite), 64'd0);
      chk({tag, "_regwrite"}, 64'(bus.RegWrite), 64'd0);
      chk({tag, "_count"},    64'(bus.InstrRetired), 64'd0);
      chk({tag, "_srcb"},     64'(bus.ALUSrcB), 64'd2);
   endtask

   initial begin
      int k;
      bus.Op = '0;
      bus.Funct3 = '0;
      bus.Zero = 1'b1;
      bus.MemReady = 1'b1;
      #12;
      check_reset_outputs("reset");
      bus.MemReady = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed: add, lw with 3 waits, beq/bne taken-on-zero, sw with 2 waits.
      run(K_R, 0, 0, -1);
      run(K_LW, 0, 3, -1);
      run(K_BEQ, 0, 0, 1);
      run(K_BNE, 0, 0, 1);
      run(K_SW, 1, 2, -1);

      // Reset in the middle of an I-type instruction.
      pend_op = OP_I; pend_f3 = 3'b000; load_ir = 1'b1;
      cyc(P_FETCH, 1'b1, -1);
      rnd(P_DECODE);
      rnd(P_EXECI);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      bus.MemReady = 1'b1;
      #1;
      check_reset_outputs("midreset");
      mcnt = '0;
      bus.MemReady = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      run(K_R, 0, 0, -1);

`ifndef ILLEGAL_TRAP_EN
      run(K_ILL, 0, 0, -1);
`endif

      // Randomized instruction stream; long enough for the counter to wrap.
      for (int n = 0; n < 320; n++) begin
         k = $urandom_range(0, 5);
`ifndef ILLEGAL_TRAP_EN
         if ($urandom_range(0, 9) == 0) k = K_ILL + 1;
`endif
         run(k, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, -1);
      end

`ifdef ILLEGAL_TRAP_EN
      run(K_ILL, 0, 0, -1);
`endif

      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
